enc_case: RTL and testbench

ENC_CASE -- requirements
Module: enc_case

---
 rtl/enc_case_if.sv | 9 +
 rtl/enc_case.sv | 47 ++++
 tb/tb_enc_case.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/enc_case_if.sv
// Request/result bundle for the registered priority encoder.
// The master drives the request vector Y and the slave returns the result A.
interface enc_case_if;
    logic [3:0] Y;
    logic [3:0] A;

    modport master (output Y, input A);
    modport slave  (input Y, output A);
endinterface

// File: rtl/enc_case.sv
// Registered 4-input priority encoder: A = {multi, valid, index} of Y, one cycle late.
// Bit 3 of Y has the highest priority; any Y that is not fully known decodes to 0000.
module enc_case (
    input  logic       clk,
    input  logic       rst_n,
    enc_case_if.slave  bus
);

    logic [3:0] a_s;
    logic [3:0] a_r;

    // Full decode of Y; items are exact 0/1 patterns so X/Z requests fall to default.
    always_comb begin
        a_s = 4'b0000;
        case (bus.Y)
            4'b0000: a_s = 4'b0000;
            4'b0001: a_s = 4'b0100;
            4'b0010: a_s = 4'b0101;
            4'b0011: a_s = 4'b1101;
            4'b0100: a_s = 4'b0110;
            4'b0101: a_s = 4'b1110;
            4'b0110: a_s = 4'b1110;
            4'b0111: a_s = 4'b1110;
            4'b1000: a_s = 4'b0111;
            4'b1001: a_s = 4'b1111;
            4'b1010: a_s = 4'b1111;
            4'b1011: a_s = 4'b1111;
            4'b1100: a_s = 4'b1111;
            4'b1101: a_s = 4'b1111;
            4'b1110: a_s = 4'b1111;
            4'b1111: a_s = 4'b1111;
            default: a_s = 4'b0000;
        endcase
    end

    // Output register; the only path from Y to A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= 4'b0000;
        end else begin
            a_r <= a_s;
        end
    end

    assign bus.A = a_r;

endmodule

// File: tb/tb_enc_case.sv
// Self-checking bench for enc_case: directed reset/glitch/latency cases plus
// randomized requests against an arithmetic priority-encoder model.
module tb_enc_case;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   bad_cnt;

    enc_case_if bus_if ();

    enc_case u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of highest set bit, any-set flag, two-or-more flag.
    function automatic logic [3:0] ref_enc(input logic [3:0] y);
        int hi;
        int n;
        hi = 0;
        n  = 0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) begin
                hi = i;
                n  = n + 1;
            end
        end
        return {(n >= 2), (n > 0), 2'(hi)};
    endfunction

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt = total_cnt + 1;
        if (obs !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply y before the next rising edge and check A just after it.
    task automatic step_check(input string tag, input logic [3:0] y);
        @(negedge clk);
        bus_if.Y = y;
        @(posedge clk);
        #1;
        check_val(tag, bus_if.A, ref_enc(y));
    endtask

    logic [3:0] y_r;
    logic [3:0] exp_a;

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b0;
        bus_if.Y  = 4'b1111;

        // Reset held with all requests active.
        #2;
        check_val("reset_hold_pre", bus_if.A, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_val("reset_hold", bus_if.A, 4'b0000);
        end

        // First edge after release loads from Y, then full sweep back-to-back.
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.Y = 4'b0011;
        @(posedge clk);
        #1;
        check_val("first_after_reset", bus_if.A, 4'b1101);
        for (int v = 0; v < 16; v++) begin
            step_check("sweep", 4'(v));
            #3;
            check_val("sweep_hold", bus_if.A, ref_enc(4'(v)));
        end
        step_check("table_0011", 4'b0011);
        check_val("table_0011_const", bus_if.A, 4'b1101);
        step_check("table_1000", 4'b1000);
        check_val("table_1000_const", bus_if.A, 4'b0111);

        // Glitch to 1000 strictly between edges must not reach A.
        step_check("glitch_base", 4'b0100);
        #2 bus_if.Y = 4'b1000;
        #1;
        check_val("glitch_mid", bus_if.A, 4'b0110);
        #1 bus_if.Y = 4'b0100;
        @(posedge clk);
        #1;
        check_val("glitch_after", bus_if.A, 4'b0110);

        // Asynchronous reset mid-cycle, then recovery on first edge.
        step_check("pre_async", 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_clear", bus_if.A, 4'b0000);
        @(posedge clk);
        #1;
        check_val("async_held", bus_if.A, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("async_release", bus_if.A, 4'b1111);

        // Valid drops with one-cycle latency.
        step_check("valid_on", 4'b0001);
        check_val("valid_on_const", bus_if.A, 4'b0100);
        step_check("valid_off", 4'b0000);
        check_val("valid_off_const", bus_if.A, 4'b0000);

        // Randomized requests with occasional glitches and async resets.
        exp_a = bus_if.A;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            y_r = 4'($urandom_range(0, 15));
            bus_if.Y = y_r;
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                #1;
                check_val("rand_rst", bus_if.A, 4'b0000);
                @(posedge clk);
                #1;
                check_val("rand_rst_edge", bus_if.A, 4'b0000);
                rst_n = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                exp_a = ref_enc(y_r);
                check_val("rand", bus_if.A, exp_a);
                if ($urandom_range(0, 3) == 0) begin
                    #1 bus_if.Y = 4'($urandom_range(0, 15));
                    #1 bus_if.Y = y_r;
                    check_val("rand_glitch", bus_if.A, exp_a);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
